spi_cmd_decoder: RTL and testbench

- Consumes the byte stream from the SPI slave receiver and assembles 6-byte SD-style command frames: start byte, 32-bit argument MSB first, CRC7/end byte.
- Checks CRC7, executes a small command set that drives the board LEDs, and queues response bytes for the slave transmitter.
- Sits between spi_slave (rx byte/strobe in, tx byte/strobe out) and the LED pins of the SPI_Blinky top level.

---
 rtl/spi_cmd_decoder_if.sv | 11 +
 rtl/spi_cmd_decoder.sv | 175 +++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Byte handshake between the SPI slave shifter and the command decoder.
// The decoder takes the slave modport; the shifter side takes master.
interface spi_cmd_decoder_if;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic [7:0] tx_byte;
  logic       tx_rdy;

  modport master (output rx_byte, output rx_rdy, input tx_byte, input tx_rdy);
  modport slave  (input rx_byte, input rx_rdy, output tx_byte, output tx_rdy);
endinterface

// File: rtl/spi_cmd_decoder.sv
// Assembles 6-byte SD-style command frames from the SPI byte stream, checks CRC7,
// drives the LED register and queues R1/data response bytes for the shifter.
module spi_cmd_decoder #(
  parameter int NUM_LEDS       = 5,
  parameter bit CHECK_CRC      = 1'b1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                i_clk,
  input  logic                i_sys_rst,
  input  logic                i_cs,
  spi_cmd_decoder_if.slave    bus,
  output logic [NUM_LEDS-1:0] o_led,
  output logic                o_cmd_err,
  output logic                o_busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARG  = 3'd1;
  localparam logic [2:0] CRC  = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
  localparam logic [5:0] CMD_SET_LED  = 6'd16;
  localparam logic [5:0] CMD_READ_LED = 6'd17;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state;
  logic                cs_meta, cs_sync;
  logic [5:0]          cmd;
  logic [NUM_LEDS-1:0] arg_led;
  logic [6:0]          crc;
  logic [1:0]          byte_cnt;
  logic [TW-1:0]       timeout_cnt;
  logic                crc_err;
  logic                adv_pend;
  logic                resp_pending;
  logic [7:0]          resp_data;
  logic                crc_ok;
  logic [7:0]          led_ext;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc_ok  = (CHECK_CRC == 1'b0) || (bus.rx_byte == {crc, 1'b1});
  assign led_ext = 8'(o_led);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= i_cs;
      cs_sync <= cs_meta;
    end
  end

  // Only arg[NUM_LEDS-1:0] affects any command, so the argument shift keeps just those bits.
  always_ff @(posedge i_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state        <= IDLE;
      cmd          <= '0;
      arg_led      <= '0;
      crc          <= '0;
      byte_cnt     <= '0;
      timeout_cnt  <= '0;
      crc_err      <= 1'b0;
      adv_pend     <= 1'b0;
      resp_pending <= 1'b0;
      resp_data    <= 8'hFF;
      o_led        <= '0;
      o_cmd_err    <= 1'b0;
      bus.tx_byte  <= 8'hFF;
      bus.tx_rdy   <= 1'b0;
    end else begin
      bus.tx_rdy <= 1'b0;
      o_cmd_err  <= 1'b0;
      if (cs_sync) begin
        state        <= IDLE;
        byte_cnt     <= '0;
        timeout_cnt  <= '0;
        adv_pend     <= 1'b0;
        resp_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.rx_rdy && (bus.rx_byte[7:6] == 2'b01)) begin
              cmd         <= bus.rx_byte[5:0];
              crc         <= crc7_next(7'd0, bus.rx_byte);
              byte_cnt    <= '0;
              timeout_cnt <= '0;
              state       <= ARG;
            end
          end
          ARG, CRC: begin
            if (bus.rx_rdy) begin
              timeout_cnt <= '0;
              if (state == ARG) begin
                arg_led  <= bus.rx_byte[NUM_LEDS-1:0];
                crc      <= crc7_next(crc, bus.rx_byte);
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) state <= CRC;
              end else begin
                crc_err <= !crc_ok;
                state   <= EXEC;
              end
            end else if (timeout_cnt == TO_LAST) begin
              timeout_cnt <= '0;
              state       <= IDLE;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
          // A strobe arriving here is remembered as the first response advance.
          EXEC: begin
            bus.tx_rdy   <= 1'b1;
            adv_pend     <= bus.rx_rdy;
            resp_pending <= 1'b0;
            state        <= RESP;
            if (crc_err) begin
              bus.tx_byte <= 8'h08;
              o_cmd_err   <= 1'b1;
            end else begin
              case (cmd)
                CMD_GO_IDLE: begin
                  o_led       <= '0;
                  bus.tx_byte <= 8'h01;
                end
                CMD_SET_LED: begin
                  o_led       <= arg_led;
                  bus.tx_byte <= 8'h00;
                end
                CMD_READ_LED: begin
                  bus.tx_byte  <= 8'h00;
                  resp_data    <= led_ext;
                  resp_pending <= 1'b1;
                end
                default: begin
                  bus.tx_byte <= 8'h04;
                  o_cmd_err   <= 1'b1;
                end
              endcase
            end
          end
          RESP: begin
            if (bus.rx_rdy || adv_pend) begin
              adv_pend   <= 1'b0;
              bus.tx_rdy <= 1'b1;
              if (resp_pending) begin
                bus.tx_byte  <= resp_data;
                resp_pending <= 1'b0;
              end else begin
                bus.tx_byte <= 8'hFF;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Drives one byte stream into two decoders (CRC checked / CRC ignored) and compares
// each against a frame-level queue model every cycle, plus hand-computed literals.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;
  localparam int NUM_LEDS = 5;
  localparam int TIMEOUT  = 16;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       cs      = 1'b0;
  logic [7:0] rx_byte = 8'hFF;
  logic       rx_rdy  = 1'b0;
  int         n_cmp   = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] model_crc7(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'b0};
    for (int b = 46; b >= 7; b--)
      if (v[b]) v[b -: 8] = v[b -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam bit CHK = (g == 0);
    spi_cmd_decoder_if bus();
    logic [NUM_LEDS-1:0] led;
    logic cmd_err, busy;
    assign bus.rx_byte = rx_byte;
    assign bus.rx_rdy  = rx_rdy;

    spi_cmd_decoder #(.NUM_LEDS(NUM_LEDS), .CHECK_CRC(CHK), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .i_clk(clk), .i_sys_rst(rst_n), .i_cs(cs), .bus(bus),
      .o_led(led), .o_cmd_err(cmd_err), .o_busy(busy));

    logic [7:0]          frame[$];
    logic [7:0]          resp[$];
    bit                  in_exec, in_resp, adv_pend, s1, s2, use_cs, crc_ok;
    int                  idle_cnt;
    logic [7:0]          m_tx_byte;
    bit                  m_tx_rdy, m_err, m_busy;
    logic [NUM_LEDS-1:0] m_led;
    logic [39:0]         hdr;

    initial begin
      forever begin
        if (!rst_n) begin
          frame.delete(); resp.delete();
          in_exec = 0; in_resp = 0; adv_pend = 0; s1 = 1; s2 = 1; idle_cnt = 0;
          m_tx_byte = 8'hFF; m_tx_rdy = 0; m_err = 0; m_led = '0;
        end else begin
          use_cs = s2; s2 = s1; s1 = cs;
          m_tx_rdy = 0; m_err = 0;
          if (use_cs) begin
            frame.delete(); resp.delete();
            in_exec = 0; in_resp = 0; adv_pend = 0; idle_cnt = 0;
          end else if (in_exec) begin
            hdr    = {frame[0], frame[1], frame[2], frame[3], frame[4]};
            crc_ok = !CHK || (frame[5] == {model_crc7(hdr), 1'b1});
            m_tx_rdy = 1;
            if (!crc_ok) begin
              m_tx_byte = 8'h08; m_err = 1;
            end else if (hdr[37:32] == 6'd0) begin
              m_led = '0; m_tx_byte = 8'h01;
            end else if (hdr[37:32] == 6'd16) begin
              m_led = hdr[NUM_LEDS-1:0]; m_tx_byte = 8'h00;
            end else if (hdr[37:32] == 6'd17) begin
              m_tx_byte = 8'h00; resp.push_back(8'(m_led));
            end else begin
              m_tx_byte = 8'h04; m_err = 1;
            end
            frame.delete();
            in_exec = 0; in_resp = 1; adv_pend = rx_rdy;
          end else if (in_resp) begin
            if (rx_rdy || adv_pend) begin
              adv_pend = 0; m_tx_rdy = 1;
              if (resp.size() != 0) m_tx_byte = resp.pop_front();
              else begin m_tx_byte = 8'hFF; in_resp = 0; end
            end
          end else if (frame.size() == 0) begin
            idle_cnt = 0;
            if (rx_rdy && rx_byte[7:6] == 2'b01) frame.push_back(rx_byte);
          end else if (rx_rdy) begin
            idle_cnt = 0;
            frame.push_back(rx_byte);
            if (frame.size() == 6) in_exec = 1;
          end else begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin frame.delete(); idle_cnt = 0; end
          end
        end
        m_busy = (frame.size() != 0) || in_exec || in_resp;
        @(posedge clk or negedge rst_n);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("crc_on.tx_byte", 32'(gen_dut[0].bus.tx_byte), 32'(gen_dut[0].m_tx_byte));
        checkOutput("crc_on.tx_rdy",  32'(gen_dut[0].bus.tx_rdy),  32'(gen_dut[0].m_tx_rdy));
        checkOutput("crc_on.led",     32'(gen_dut[0].led),         32'(gen_dut[0].m_led));
        checkOutput("crc_on.cmd_err", 32'(gen_dut[0].cmd_err),     32'(gen_dut[0].m_err));
        checkOutput("crc_on.busy",    32'(gen_dut[0].busy),        32'(gen_dut[0].m_busy));
        checkOutput("crc_off.tx_byte", 32'(gen_dut[1].bus.tx_byte), 32'(gen_dut[1].m_tx_byte));
        checkOutput("crc_off.tx_rdy",  32'(gen_dut[1].bus.tx_rdy),  32'(gen_dut[1].m_tx_rdy));
        checkOutput("crc_off.led",     32'(gen_dut[1].led),         32'(gen_dut[1].m_led));
        checkOutput("crc_off.cmd_err", 32'(gen_dut[1].cmd_err),     32'(gen_dut[1].m_err));
        checkOutput("crc_off.busy",    32'(gen_dut[1].busy),        32'(gen_dut[1].m_busy));
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [7:0] b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, b4, b5);
    applyStimulus(b0); idle(1);
    applyStimulus(b1); idle(1);
    applyStimulus(b2); idle(1);
    applyStimulus(b3); idle(1);
    applyStimulus(b4); idle(1);
    applyStimulus(b5);
  endtask

  task automatic goodFrame(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] h;
    h = {2'b01, c, a};
    sendFrame(h[39:32], h[31:24], h[23:16], h[15:8], h[7:0], {model_crc7(h), 1'b1});
  endtask

  task automatic finishResp();
    applyStimulus(8'hFF);
    idle(1);
  endtask

  initial begin
    checkOutput("model_crc_cmd0",  32'(model_crc7(40'h40_0000_0000)), 'h4A);
    checkOutput("model_crc_cmd17", 32'(model_crc7(40'h51_0000_0000)), 'h2A);
    checkOutput("model_crc_cmd8",  32'(model_crc7(40'h48_0000_01AA)), 'h43);

    idle(3);
    checkOutput("rst_led",     32'(gen_dut[0].led), 0);
    checkOutput("rst_tx_byte", 32'(gen_dut[0].bus.tx_byte), 'hFF);
    checkOutput("rst_tx_rdy",  32'(gen_dut[0].bus.tx_rdy), 0);
    checkOutput("rst_busy",    32'(gen_dut[1].busy), 0);
    rst_n = 1'b1;
    idle(4);

    // CMD0 with correct CRC
    applyStimulus(8'h40);
    checkOutput("cmd0_busy_first", 32'(gen_dut[0].busy), 1);
    idle(1);
    applyStimulus(8'h00); idle(1); applyStimulus(8'h00); idle(1);
    applyStimulus(8'h00); idle(1); applyStimulus(8'h00); idle(1);
    applyStimulus(8'h95);
    checkOutput("cmd0_exec_no_rdy", 32'(gen_dut[0].bus.tx_rdy), 0);
    idle(1);
    checkOutput("cmd0_r1_rdy", 32'(gen_dut[0].bus.tx_rdy), 1);
    checkOutput("cmd0_r1",     32'(gen_dut[0].bus.tx_byte), 'h01);
    checkOutput("cmd0_err",    32'(gen_dut[0].cmd_err), 0);
    idle(1);
    checkOutput("cmd0_rdy_single", 32'(gen_dut[0].bus.tx_rdy), 0);
    applyStimulus(8'hFF);
    checkOutput("cmd0_tail",      32'(gen_dut[0].bus.tx_byte), 'hFF);
    checkOutput("cmd0_tail_idle", 32'(gen_dut[0].busy), 0);
    idle(1);

    // CMD16 with garbage CRC: accepted only where CRC is ignored
    sendFrame(8'h50, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hFF);
    idle(1);
    checkOutput("nocrc_led", 32'(gen_dut[1].led), 'h05);
    checkOutput("nocrc_r1",  32'(gen_dut[1].bus.tx_byte), 'h00);
    applyStimulus(8'hFF);
    checkOutput("nocrc_tail", 32'(gen_dut[1].bus.tx_byte), 'hFF);
    checkOutput("nocrc_idle", 32'(gen_dut[1].busy), 0);
    idle(1);

    goodFrame(6'd16, 32'h0000_0015);
    idle(1);
    checkOutput("set_led_15", 32'(gen_dut[0].led), 'h15);
    finishResp();

    // CMD17 readback
    sendFrame(8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
    idle(1);
    checkOutput("cmd17_r1", 32'(gen_dut[0].bus.tx_byte), 'h00);
    applyStimulus(8'hFF);
    checkOutput("cmd17_data",     32'(gen_dut[0].bus.tx_byte), 'h15);
    checkOutput("cmd17_data_rdy", 32'(gen_dut[0].bus.tx_rdy), 1);
    idle(1);
    applyStimulus(8'hFF);
    checkOutput("cmd17_tail", 32'(gen_dut[0].bus.tx_byte), 'hFF);
    checkOutput("cmd17_idle", 32'(gen_dut[0].busy), 0);
    idle(1);

    // Bad CRC, then illegal command
    sendFrame(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97);
    idle(1);
    checkOutput("badcrc_r1",  32'(gen_dut[0].bus.tx_byte), 'h08);
    checkOutput("badcrc_err", 32'(gen_dut[0].cmd_err), 1);
    checkOutput("badcrc_led", 32'(gen_dut[0].led), 'h15);
    finishResp();
    sendFrame(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87);
    idle(1);
    checkOutput("illegal_r1",  32'(gen_dut[0].bus.tx_byte), 'h04);
    checkOutput("illegal_err", 32'(gen_dut[1].cmd_err), 1);
    finishResp();

    // Strobe during EXEC counts as the first response advance
    sendFrame(8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
    applyStimulus(8'hFF);
    checkOutput("exec_strobe_r1", 32'(gen_dut[0].bus.tx_byte), 'h00);
    idle(1);
    checkOutput("exec_strobe_data", 32'(gen_dut[0].bus.tx_byte), 'h15);
    checkOutput("exec_strobe_rdy",  32'(gen_dut[0].bus.tx_rdy), 1);
    idle(1);
    finishResp();

    // Inter-byte timeout
    applyStimulus(8'h50); idle(1);
    applyStimulus(8'h00);
    idle(TIMEOUT - 1);
    checkOutput("timeout_still_busy", 32'(gen_dut[0].busy), 1);
    idle(2);
    checkOutput("timeout_idle", 32'(gen_dut[0].busy), 0);
    goodFrame(6'd0, 32'h0);
    idle(1);
    checkOutput("after_timeout_r1", 32'(gen_dut[0].bus.tx_byte), 'h01);
    finishResp();

    // Chip-select abort
    applyStimulus(8'h40); idle(1); applyStimulus(8'h00); idle(1); applyStimulus(8'h00);
    cs = 1'b1;
    idle(3);
    checkOutput("cs_abort_idle", 32'(gen_dut[0].busy), 0);
    cs = 1'b0;
    idle(3);
    goodFrame(6'd0, 32'h0);
    idle(1);
    checkOutput("after_cs_r1",  32'(gen_dut[0].bus.tx_byte), 'h01);
    checkOutput("after_cs_rdy", 32'(gen_dut[0].bus.tx_rdy), 1);
    finishResp();

    // Asynchronous reset mid-frame
    goodFrame(6'd16, 32'h0000_000A);
    idle(1);
    checkOutput("set_led_0a", 32'(gen_dut[1].led), 'h0A);
    finishResp();
    applyStimulus(8'h40); idle(1); applyStimulus(8'h00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_led",  32'(gen_dut[0].led), 0);
    checkOutput("async_rst_tx",   32'(gen_dut[0].bus.tx_byte), 'hFF);
    checkOutput("async_rst_busy", 32'(gen_dut[0].busy), 0);
    checkOutput("async_rst_led1", 32'(gen_dut[1].led), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    applyStimulus(8'hFF); idle(1);
    applyStimulus(8'hFF);
    checkOutput("ff_ignored_busy", 32'(gen_dut[0].busy), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
